// File: rtl/keyed_lut_reg.sv
// rtl/keyed_lut_reg.sv - registered key->data lookup table with valid bits and handshaked lookups
// Lookups compare against the table as it stood before any same-cycle write/invalidate/flush.
module keyed_lut_reg #(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 8,
  parameter int DATA_LEN    = 32,
  parameter int HAS_DEFAULT = 1,
  parameter int PRIORITY    = 0,
  localparam int IDX_W      = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_LEN-1:0]  req_key,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_hit,
  output logic                resp_multi,
  output logic [DATA_LEN-1:0] resp_data,
  input  logic [DATA_LEN-1:0] default_out,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                inv_en,
  input  logic [IDX_W-1:0]    inv_idx,
  input  logic                flush,
  output logic [IDX_W:0]      valid_cnt
);

  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];
  logic [NR_KEY-1:0]   valid_q, valid_d;
  logic [IDX_W:0]      valid_cnt_q, valid_cnt_d;

  logic                resp_valid_q, resp_hit_q, resp_multi_q;
  logic [DATA_LEN-1:0] resp_data_q;

  logic [NR_KEY-1:0]   match;
  logic [IDX_W:0]      match_cnt;
  logic [DATA_LEN-1:0] or_data, prio_data, lookup_data;
  logic                accept;

  assign req_ready = !resp_valid_q | resp_ready;
  assign accept    = req_valid & req_ready;

  always_comb begin
    match       = '0;
    match_cnt   = '0;
    or_data     = '0;
    prio_data   = '0;
    lookup_data = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      match[i]  = valid_q[i] && (key_q[i] == req_key);
      match_cnt = match_cnt + {{IDX_W{1'b0}}, match[i]};
      if (match[i]) or_data = or_data | data_q[i];
    end
    // Descending scan so the lowest matching index is the last one assigned.
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (match[i]) prio_data = data_q[i];
    end
    if (match == '0) lookup_data = (HAS_DEFAULT != 0) ? default_out : '0;
    else             lookup_data = (PRIORITY != 0) ? prio_data : or_data;
  end

  always_comb begin
    valid_d     = valid_q;
    valid_cnt_d = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (wr_en && int'(wr_idx) == i)        valid_d[i] = 1'b1;
      else if (flush)                        valid_d[i] = 1'b0;
      else if (inv_en && int'(inv_idx) == i) valid_d[i] = 1'b0;
      valid_cnt_d = valid_cnt_d + {{IDX_W{1'b0}}, valid_d[i]};
    end
  end

  // Key/data storage carries no reset; the valid bits alone gate matching.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NR_KEY; i++) begin
      if (wr_en && int'(wr_idx) == i) begin
        key_q[i]  <= wr_key;
        data_q[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q     <= '0;
      valid_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      valid_cnt_q <= valid_cnt_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_multi_q <= 1'b0;
      resp_data_q  <= '0;
    end else if (accept) begin
      resp_valid_q <= 1'b1;
      resp_hit_q   <= |match;
      resp_multi_q <= (match_cnt >= 2);
      resp_data_q  <= lookup_data;
    end else if (resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_multi = resp_multi_q;
  assign resp_data  = resp_data_q;
  assign valid_cnt  = valid_cnt_q;

endmodule

// File: tb/tb_keyed_lut_reg.sv
// tb/tb_keyed_lut_reg.sv - scoreboard bench for keyed_lut_reg (OR/default and priority/no-default builds)
module tb_keyed_lut_reg;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, resp_ready = 1'b0;
  logic        wr_en = 1'b0, inv_en = 1'b0, flush = 1'b0;
  logic [7:0]  req_key = '0, wr_key = '0;
  logic [31:0] default_out = '0, wr_data = '0;
  logic [1:0]  wr_idx = '0, inv_idx = '0;

  logic        req_ready0, resp_valid0, hit0, multi0;
  logic        req_ready1, resp_valid1, hit1, multi1;
  logic [31:0] data0, data1;
  logic [2:0]  cnt0, cnt1;

  always #5 clock = ~clock;

  keyed_lut_reg #(.PRIORITY(0), .HAS_DEFAULT(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready0),
    .req_key(req_key), .resp_valid(resp_valid0), .resp_ready(resp_ready), .resp_hit(hit0),
    .resp_multi(multi0), .resp_data(data0), .default_out(default_out), .wr_en(wr_en),
    .wr_idx(wr_idx), .wr_key(wr_key), .wr_data(wr_data), .inv_en(inv_en), .inv_idx(inv_idx),
    .flush(flush), .valid_cnt(cnt0));

  keyed_lut_reg #(.PRIORITY(1), .HAS_DEFAULT(0)) dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready1),
    .req_key(req_key), .resp_valid(resp_valid1), .resp_ready(resp_ready), .resp_hit(hit1),
    .resp_multi(multi1), .resp_data(data1), .default_out(default_out), .wr_en(wr_en),
    .wr_idx(wr_idx), .wr_key(wr_key), .wr_data(wr_data), .inv_en(inv_en), .inv_idx(inv_idx),
    .flush(flush), .valid_cnt(cnt1));

  typedef struct {
    logic        hit;
    logic        multi;
    logic [31:0] d_or;
    logic [31:0] d_prio;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  m_key  [4];
  logic [31:0] m_data [4];
  bit          m_valid[4];
  bit          m_rv = 1'b0;
  int          n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 4; i++) n += m_valid[i];
    return n;
  endfunction

  // Reference: lookup against the current table, then apply write/flush/invalidate.
  always @(posedge clock) begin : model
    exp_t e;
    int   hits;
    if (reset_n) begin
      if (req_valid && (!m_rv || resp_ready)) begin
        hits = 0; e.d_or = '0; e.d_prio = '0;
        for (int i = 3; i >= 0; i--) begin
          if (m_valid[i] && m_key[i] == req_key) begin
            hits++;
            e.d_or   = e.d_or | m_data[i];
            e.d_prio = m_data[i];
          end
        end
        e.hit   = (hits > 0);
        e.multi = (hits > 1);
        if (hits == 0) begin
          e.d_or   = default_out;
          e.d_prio = '0;
        end
        sb_q.push_back(e);
        m_rv = 1'b1;
      end else if (resp_ready) begin
        m_rv = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (wr_en && int'(wr_idx) == i) begin
          m_valid[i] = 1'b1; m_key[i] = wr_key; m_data[i] = wr_data;
        end else if (flush || (inv_en && int'(inv_idx) == i)) begin
          m_valid[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chk("req_ready0", {31'd0, req_ready0}, {31'd0, !m_rv || resp_ready});
      chk("req_ready1", {31'd0, req_ready1}, {31'd0, !m_rv || resp_ready});
      chk("resp_valid0", {31'd0, resp_valid0}, {31'd0, m_rv});
      chk("resp_valid1", {31'd0, resp_valid1}, {31'd0, m_rv});
      chk("valid_cnt0", {29'd0, cnt0}, 32'(m_count()));
      chk("valid_cnt1", {29'd0, cnt1}, 32'(m_count()));
      if (m_rv && sb_q.size() > 0) begin
        chk("hit0", {31'd0, hit0}, {31'd0, sb_q[0].hit});
        chk("multi0", {31'd0, multi0}, {31'd0, sb_q[0].multi});
        chk("data0", data0, sb_q[0].d_or);
        chk("hit1", {31'd0, hit1}, {31'd0, sb_q[0].hit});
        chk("multi1", {31'd0, multi1}, {31'd0, sb_q[0].multi});
        chk("data1", data1, sb_q[0].d_prio);
        if (resp_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    req_valid = 1'b0; wr_en = 1'b0; inv_en = 1'b0; flush = 1'b0;
  endtask

  task automatic lookup(input logic [7:0] k);
    req_valid = 1'b1; req_key = k;
  endtask

  task automatic write(input logic [1:0] idx, input logic [7:0] k, input logic [31:0] d);
    wr_en = 1'b1; wr_idx = idx; wr_key = k; wr_data = d;
  endtask

  logic [7:0] keys[4];

  initial begin
    keys[0] = 8'h12; keys[1] = 8'h34; keys[2] = 8'h56; keys[3] = 8'h78;
    #2;
    chk("rst resp_valid", {31'd0, resp_valid0}, 32'd0);
    chk("rst hit", {31'd0, hit0}, 32'd0);
    chk("rst multi", {31'd0, multi1}, 32'd0);
    chk("rst data", data0 | data1, 32'd0);
    chk("rst valid_cnt", {29'd0, cnt0 | cnt1}, 32'd0);
    chk("rst req_ready", {31'd0, req_ready0 & req_ready1}, 32'd1);
    @(posedge clock); #1;
    reset_n = 1'b1; resp_ready = 1'b1;

    default_out = 32'hDEAD; lookup(8'h12); tick(); tick();
    write(2'd0, 8'h12, 32'hA5A5); tick();
    write(2'd3, 8'h34, 32'h0F0F); tick();
    lookup(8'h34); tick(); tick();
    write(2'd1, 8'h12, 32'h5A00); tick();
    lookup(8'h12); tick(); tick();

    // Stall three cycles with a pending request, then stream back-to-back.
    lookup(8'h12); tick();
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin lookup(8'h34); tick(); end
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin lookup(keys[i]); tick(); end
    tick();

    // Lookup colliding with flush and write.
    lookup(8'h12); flush = 1'b1; write(2'd2, 8'h56, 32'h1); tick();
    lookup(8'h12); tick(); tick();

    // Reset while a response is stalled.
    resp_ready = 1'b0; lookup(8'h56); tick();
    #2 reset_n = 1'b0;
    #1;
    chk("midrst resp_valid", {30'd0, resp_valid0, resp_valid1}, 32'd0);
    chk("midrst valid_cnt", {26'd0, cnt0, cnt1}, 32'd0);
    sb_q.delete(); m_rv = 1'b0;
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1; resp_ready = 1'b1;
    lookup(8'h56); tick(); tick();

    for (int n = 0; n < 400; n++) begin
      resp_ready  = ($urandom_range(0, 3) != 0);
      default_out = $urandom;
      if ($urandom_range(0, 1) == 1) lookup(keys[$urandom_range(0, 3)]);
      if ($urandom_range(0, 3) == 0) write(2'($urandom_range(0, 3)), keys[$urandom_range(0, 3)], $urandom);
      if ($urandom_range(0, 5) == 0) begin inv_en = 1'b1; inv_idx = 2'($urandom_range(0, 3)); end
      if ($urandom_range(0, 19) == 0) flush = 1'b1;
      tick();
    end
    resp_ready = 1'b1;
    tick(); tick();
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
